ring_decoder_monitor: RTL

Receive-side companion to the 8-bit one-hot ring counter. It samples the counter's `count` bus every `clk` and decodes the hot bit to a binary index. It also checks that the value is one-hot and that it advances by exactly one left-rotation per cycle. It reports lock and fault status, plus wrap and error counts, for the bench and for downstream logic.

---
 rtl/ring_pkg.sv | 17 +
 rtl/ring_decoder_monitor_if.sv | 24 ++
 rtl/onehot_to_bin.sv | 17 +
 rtl/ring_decoder_monitor.sv | 90 +++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// ring_pkg: shared FSM state type, default ring width and one-hot ring helpers
package ring_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE, ACQ, LOCKED, FAULT} state_t;
  function automatic logic [63:0] mask(input int w);
    return (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
  endfunction
  function automatic logic [63:0] rotl1(input logic [63:0] v, input int w);
    return ((v << 1) | (v >> (w - 1))) & mask(w);
  endfunction
  function automatic logic [63:0] rotr1(input logic [63:0] v, input int w);
    return ((v >> 1) | (v << (w - 1))) & mask(w);
  endfunction
  function automatic logic is_onehot(input logic [63:0] v);
    return (v != '0) && ((v & (v - 64'd1)) == '0);
  endfunction
endpackage

// File: rtl/ring_decoder_monitor_if.sv
// ring_decoder_monitor_if: ring sample input and monitor status bundle (RING_DIR_DETECT_EN adds dir)
interface ring_decoder_monitor_if #(
  parameter int WIDTH = ring_pkg::WIDTH_DEF,
  parameter int IDX_W = $clog2(WIDTH),
  parameter int ERR_W = 8,
  parameter int WRAP_W = 16
);
  logic [WIDTH-1:0] count_in;
  logic [IDX_W-1:0] index;
  logic onehot_ok;
  logic locked;
  logic seq_err;
  logic wrap;
  logic [ERR_W-1:0] err_count;
  logic [WRAP_W-1:0] wrap_count;
`ifdef RING_DIR_DETECT_EN
  logic dir;
  modport master (output count_in, input index, onehot_ok, locked, seq_err, wrap, err_count, wrap_count, dir);
  modport slave (input count_in, output index, onehot_ok, locked, seq_err, wrap, err_count, wrap_count, dir);
`else
  modport master (output count_in, input index, onehot_ok, locked, seq_err, wrap, err_count, wrap_count);
  modport slave (input count_in, output index, onehot_ok, locked, seq_err, wrap, err_count, wrap_count);
`endif
endinterface

// File: rtl/onehot_to_bin.sv
// onehot_to_bin: one-hot to binary index encoder with one-hot valid flag
module onehot_to_bin
  import ring_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) idx = vec[i] ? idx | IDX_W'(i) : idx;
  end
  assign valid = is_onehot(64'(vec));
endmodule

// File: rtl/ring_decoder_monitor.sv
// ring_decoder_monitor: one-hot ring decode, rotation lock FSM and fault/wrap counters (RING_DIR_DETECT_EN adds direction detect)
module ring_decoder_monitor
  import ring_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDX_W = $clog2(WIDTH),
  parameter int LOCK_CYCLES = 3,
  parameter int ERR_W = 8,
  parameter int WRAP_W = 16
) (
  input logic clk,
  input logic init,
  ring_decoder_monitor_if.slave bus
);
  state_t state, state_n;
  logic [WIDTH-1:0] prev, rl;
  logic [IDX_W-1:0] idx;
  logic [3:0] match, match_n;
  logic oh, prev_oh, step_l, step_ok, wrap_c, fault, wrap_n;
  onehot_to_bin #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_enc (.vec(bus.count_in), .idx(idx), .valid(oh));
  assign rl = WIDTH'(rotl1(64'(prev), WIDTH));
  assign prev_oh = is_onehot(64'(prev));
  assign step_l = oh && prev_oh && bus.count_in == rl;
`ifdef RING_DIR_DETECT_EN
  logic [WIDTH-1:0] rr;
  logic step_r, dir_r, dir_n;
  assign rr = WIDTH'(rotr1(64'(prev), WIDTH));
  assign step_r = oh && prev_oh && bus.count_in == rr;
  // the first step of an acquisition may go either way and fixes the direction
  assign step_ok = (state == ACQ && match == '0) ? step_l || step_r : (dir_r ? step_r : step_l);
  assign wrap_c = dir_r ? prev[0] && bus.count_in[WIDTH-1] : prev[WIDTH-1] && bus.count_in[0];
  assign dir_n = state == IDLE ? 1'b0 : (state == ACQ && match == '0 && step_ok) ? !step_l : dir_r;
  assign bus.dir = dir_r;
  always_ff @(posedge clk) dir_r <= init ? 1'b0 : dir_n;
`else
  assign step_ok = step_l;
  assign wrap_c = prev[WIDTH-1] && bus.count_in[0];
`endif
  always_comb begin
    state_n = state;
    match_n = match;
    fault = 1'b0;
    wrap_n = 1'b0;
    case (state)
      IDLE: begin
        state_n = oh ? ACQ : IDLE;
        match_n = '0;
      end
      ACQ: begin
        state_n = step_ok ? ((5'(match) + 5'd1 == 5'(LOCK_CYCLES)) ? LOCKED : ACQ) : (oh ? ACQ : IDLE);
        match_n = step_ok ? match + 4'd1 : '0;
      end
      LOCKED: begin
        state_n = step_ok ? LOCKED : FAULT;
        fault = !step_ok;
        wrap_n = step_ok && wrap_c;
      end
      FAULT: begin
        state_n = oh ? ACQ : FAULT;
        match_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (init) begin
      state <= IDLE;
      match <= '0;
      prev <= '0;
      bus.index <= '0;
      bus.onehot_ok <= 1'b0;
      bus.locked <= 1'b0;
      bus.seq_err <= 1'b0;
      bus.wrap <= 1'b0;
      bus.err_count <= '0;
      bus.wrap_count <= '0;
    end else begin
      state <= state_n;
      match <= match_n;
      prev <= bus.count_in;
      bus.index <= oh ? idx : bus.index;
      bus.onehot_ok <= oh;
      bus.locked <= state_n == LOCKED;
      bus.seq_err <= fault;
      bus.wrap <= wrap_n;
      bus.err_count <= bus.err_count + ERR_W'(fault && !(&bus.err_count));
      bus.wrap_count <= bus.wrap_count + WRAP_W'(wrap_n);
    end
  end
endmodule
